bram_rv_pipe: RTL and testbench

BRAM_RV_PIPE -- requirements
Module: bram_rv_pipe

---
 rtl/bram_rv_pkg.sv | 28 ++
 rtl/bram_rv_resp_buf.sv | 89 ++++++++
 rtl/bram_rv_pipe.sv | 99 +++++++++
 tb/tb_bram_rv_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rv_pkg.sv
// ============================================================================
//  Module      : bram_rv_pkg
//  Description : Shared constants and the byte-merge helper for the
//                bram_rv_pipe memory block and its response buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_rv_pkg;

    localparam int C_DEF_DATA_WIDTH = 32;
    localparam int C_DEF_ADDR_WIDTH = 10;
    localparam int C_RESP_BUF_DEPTH = 2;

    typedef logic [7:0] byte_t;

    // One byte lane of a byte-enabled write: the new byte replaces the old
    // one only when its enable is set. Used both for the memory update and
    // for the write-first collision response so the two can never disagree.
    function automatic byte_t merge_byte(input byte_t old_b,
                                         input byte_t new_b,
                                         input logic  en);
        return en ? new_b : old_b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_rv_resp_buf.sv
// ============================================================================
//  Module      : bram_rv_resp_buf
//  Description : Two-entry valid/ready FIFO with a registered output. Entry 0
//                is the output (head) register, entry 1 a skid register that
//                only fills while the head is stalled.
//  Ports       : i_clk, i_rst (async, active-low)
//                i_push_valid / o_push_ready / i_push_data  - write side
//                o_pop_valid  / i_pop_ready  / o_pop_data   - read side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rv_resp_buf
    import bram_rv_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push_valid,
    output logic                  o_push_ready,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    output logic                  o_pop_valid,
    input  logic                  i_pop_ready,
    output logic [DATA_WIDTH-1:0] o_pop_data
);

    logic [DATA_WIDTH-1:0] r_head_q, w_head_d;
    logic [DATA_WIDTH-1:0] r_skid_q, w_skid_d;
    logic                  r_head_vld_q, w_head_vld_d;
    logic                  r_skid_vld_q, w_skid_vld_d;
    logic                  w_pop;
    logic                  w_push;

    assign w_pop  = r_head_vld_q & i_pop_ready;
    // Full only when both entries hold data; an entry popped this cycle
    // counts as free, which keeps single-cycle streaming at full rate.
    assign o_push_ready = ~r_skid_vld_q | w_pop;
    assign w_push = i_push_valid & o_push_ready;

    always_comb begin
        w_head_d     = r_head_q;
        w_head_vld_d = r_head_vld_q;
        w_skid_d     = r_skid_q;
        w_skid_vld_d = r_skid_vld_q;
        if (w_pop || !r_head_vld_q) begin
            // Head slot frees up: older skid entry advances first so order
            // is preserved; a new push lands behind it.
            if (r_skid_vld_q) begin
                w_head_d     = r_skid_q;
                w_head_vld_d = 1'b1;
                w_skid_vld_d = w_push;
                if (w_push) begin
                    w_skid_d = i_push_data;
                end
            end else begin
                w_head_vld_d = w_push;
                w_skid_vld_d = 1'b0;
                if (w_push) begin
                    w_head_d = i_push_data;
                end
            end
        end else if (w_push) begin
            // Head stalled: the head data must not move, so park the push.
            w_skid_d     = i_push_data;
            w_skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_head_q     <= '0;
            r_skid_q     <= '0;
            r_head_vld_q <= 1'b0;
            r_skid_vld_q <= 1'b0;
        end else begin
            r_head_q     <= w_head_d;
            r_skid_q     <= w_skid_d;
            r_head_vld_q <= w_head_vld_d;
            r_skid_vld_q <= w_skid_vld_d;
        end
    end

    assign o_pop_valid = r_head_vld_q;
    assign o_pop_data  = r_head_q;

endmodule

`default_nettype wire

// File: rtl/bram_rv_pipe.sv
// ============================================================================
//  Module      : bram_rv_pipe
//  Description : Byte-enabled single-clock memory with a valid/ready write
//                port and a valid/ready read request/response pair. Read data
//                is sampled on request acceptance and returned one cycle later
//                through a 2-entry in-order response buffer.
//  Ports       : i_clk, i_rst (async, active-low)
//                i_wr_addr / i_wr_data / i_wr_be, i_wr_valid / o_wr_ready
//                i_rd_addr, i_rd_req_valid / o_rd_req_ready
//                o_rd_data, o_rd_valid / i_rd_ready
//  Options     : BRAM_RV_WRITE_FIRST_EN - when defined, a read and write to the
//                same address on the same edge return the merged (new) word;
//                otherwise the word as it was before the write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_rv_pipe
    import bram_rv_pkg::*;
#(
    parameter int DATA_WIDTH = C_DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = C_DEF_ADDR_WIDTH,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [BE_WIDTH-1:0]   i_wr_be,
    input  logic                  i_wr_valid,
    output logic                  o_wr_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_rd_req_valid,
    output logic                  o_rd_req_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready
);

    localparam int C_DEPTH = 1 << ADDR_WIDTH;

    // Contents are deliberately not reset so data survives a reset pulse.
    logic [DATA_WIDTH-1:0] r_mem_q [C_DEPTH];

    logic [DATA_WIDTH-1:0] w_wr_old;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_old;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_wr_fire;
    logic                  w_buf_push_ready;

    // Both ports track the reset pin directly: low throughout reset and
    // already high at the first rising edge after release.
    assign o_wr_ready = i_rst;
    assign w_wr_fire  = i_wr_valid & o_wr_ready;

    assign w_wr_old = r_mem_q[i_wr_addr];

    for (genvar k = 0; k < BE_WIDTH; k++) begin : g_byte_merge
        assign w_wr_merged[8*k +: 8] =
            merge_byte(w_wr_old[8*k +: 8], i_wr_data[8*k +: 8], i_wr_be[k]);
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_fire) begin
            r_mem_q[i_wr_addr] <= w_wr_merged;
        end
    end

    // The word is captured straight into the response buffer on acceptance,
    // so the buffer head register doubles as the memory output register and
    // nothing is ever left in flight between the array and the buffer.
    assign w_rd_old = r_mem_q[i_rd_addr];

`ifdef BRAM_RV_WRITE_FIRST_EN
    assign w_rd_word = (w_wr_fire && (i_wr_addr == i_rd_addr)) ? w_wr_merged
                                                                : w_rd_old;
`else
    assign w_rd_word = w_rd_old;
`endif

    assign o_rd_req_ready = w_buf_push_ready & i_rst;

    bram_rv_resp_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_buf (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push_valid (i_rd_req_valid & i_rst),
        .o_push_ready (w_buf_push_ready),
        .i_push_data  (w_rd_word),
        .o_pop_valid  (o_rd_valid),
        .i_pop_ready  (i_rd_ready),
        .o_pop_data   (o_rd_data)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_rv_pipe.sv
// ============================================================================
//  Module      : tb_bram_rv_pipe
//  Description : Self-checking bench for bram_rv_pipe: directed scenarios with
//                literal expectations followed by randomized traffic checked
//                against a queue/array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_rv_pipe;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic [BW-1:0] i_wr_be = '0;
    logic          i_wr_valid = 1'b0;
    logic          o_wr_ready;
    logic [AW-1:0] i_rd_addr = '0;
    logic          i_rd_req_valid = 1'b0;
    logic          o_rd_req_ready;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_valid;
    logic          i_rd_ready = 1'b0;

    bram_rv_pipe dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_wr_be        (i_wr_be),
        .i_wr_valid     (i_wr_valid),
        .o_wr_ready     (o_wr_ready),
        .i_rd_addr      (i_rd_addr),
        .i_rd_req_valid (i_rd_req_valid),
        .o_rd_req_ready (o_rd_req_ready),
        .o_rd_data      (o_rd_data),
        .o_rd_valid     (o_rd_valid),
        .i_rd_ready     (i_rd_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: memory as an associative array, responses as a
    // queue of words in request order, capacity two.
    // ------------------------------------------------------------------
    logic [31:0] mdl_mem [int];
    logic [31:0] mdl_q [$];

    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 32'h0;
    endfunction

    // A request is accepted if, after any pop this cycle, fewer than two
    // responses would be held.
    function automatic logic mdl_req_ready();
        int occ;
        occ = mdl_q.size();
        if (occ > 0 && i_rd_ready) occ = occ - 1;
        return i_rst && (occ < 2);
    endfunction

    always @(posedge i_clk) begin
        if (i_rst) begin
            logic        acc_r;
            logic        pop;
            logic [31:0] word;
            pop   = (mdl_q.size() > 0) && i_rd_ready;
            acc_r = i_rd_req_valid && mdl_req_ready();
            word  = mem_word(i_rd_addr);
`ifdef BRAM_RV_WRITE_FIRST_EN
            if (i_wr_valid && i_wr_addr == i_rd_addr)
                word = apply_be(word, i_wr_data, i_wr_be);
`endif
            if (pop) void'(mdl_q.pop_front());
            if (acc_r) mdl_q.push_back(word);
            if (i_wr_valid)
                mdl_mem[int'(i_wr_addr)] = apply_be(mem_word(i_wr_addr), i_wr_data, i_wr_be);
        end
    end

    always @(negedge i_rst) mdl_q.delete();

    // Compare process: inputs change 1 time unit after the rising edge, so
    // the falling edge sees settled outputs.
    always @(negedge i_clk) begin
        if (i_rst) begin
            check("wr_ready", 32'(o_wr_ready), 32'd1);
            check("rd_req_ready", 32'(o_rd_req_ready), 32'(mdl_req_ready()));
            check("rd_valid", 32'(o_rd_valid), 32'(mdl_q.size() > 0));
            if (mdl_q.size() > 0) check("rd_data", o_rd_data, mdl_q[0]);
        end
    end

    // ------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        i_wr_valid = 1'b1; i_wr_addr = a; i_wr_data = d; i_wr_be = be;
        tick();
        i_wr_valid = 1'b0;
    endtask

    task automatic rd_check(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        i_rd_ready = 1'b1; i_rd_req_valid = 1'b1; i_rd_addr = a;
        tick();
        i_rd_req_valid = 1'b0;
        check({name, "_valid"}, 32'(o_rd_valid), 32'd1);
        check({name, "_data"}, o_rd_data, exp);
        tick();
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 31));
        return (r < 16) ? AW'(r) : AW'(1008 + r - 16);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp4 [4];
        logic [AW-1:0] a4 [4];
        int idx, got;
        logic acc, pop;
        logic [31:0] d;

        exp4[0] = 32'hAA; exp4[1] = 32'hBB; exp4[2] = 32'hCC; exp4[3] = 32'h1122FF44;
        a4[0] = 10'd21; a4[1] = 10'd22; a4[2] = 10'd23; a4[3] = 10'd5;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_wr_ready", 32'(o_wr_ready), 32'd0);
        check("rst_rd_req_ready", 32'(o_rd_req_ready), 32'd0);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_rd_data", o_rd_data, 32'd0);
        i_rst = 1'b1;
        #1;
        check("rel_wr_ready", 32'(o_wr_ready), 32'd1);
        check("rel_rd_req_ready", 32'(o_rd_req_ready), 32'd1);
        tick();

        // Basic write/read and byte-enable merge
        wr(10'd21, 32'h000000AA, 4'hF);
        rd_check(10'd21, 32'h000000AA, "basic21");
        wr(10'd5, 32'h11223344, 4'hF);
        wr(10'd5, 32'hFFFFFFFF, 4'h2);
        rd_check(10'd5, 32'h1122FF44, "be_merge");
        wr(10'd5, 32'hDEADBEEF, 4'h0);
        rd_check(10'd5, 32'h1122FF44, "be_zero");

        // Back-to-back reads at full rate
        wr(10'd22, 32'hBB, 4'hF);
        wr(10'd23, 32'hCC, 4'hF);
        i_rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_rd_req_valid = 1'b1; i_rd_addr = a4[i];
            tick();
            check("b2b_valid", 32'(o_rd_valid), 32'd1);
            check("b2b_data", o_rd_data, exp4[i]);
        end
        i_rd_req_valid = 1'b0;
        tick();

        // Backpressure: only two accepted, then drain in order
        idx = 0; got = 0;
        i_rd_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            i_rd_req_valid = 1'b1; i_rd_addr = a4[idx];
            #1;
            acc = o_rd_req_ready;
            tick();
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), 32'd2);
        check("bp_req_ready_low", 32'(o_rd_req_ready), 32'd0);
        i_rd_ready = 1'b1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            i_rd_req_valid = (idx < 4);
            if (idx < 4) i_rd_addr = a4[idx];
            #1;
            acc = i_rd_req_valid && o_rd_req_ready;
            pop = o_rd_valid;
            d = o_rd_data;
            tick();
            if (acc) idx++;
            if (pop) begin
                if (got < 4) check("bp_resp", d, exp4[got]);
                got++;
            end
        end
        i_rd_req_valid = 1'b0;
        check("bp_resp_count", 32'(got), 32'd4);
        tick();

        // Same-edge read/write collision
        wr(10'd7, 32'hAA, 4'hF);
        i_wr_valid = 1'b1; i_wr_addr = 10'd7; i_wr_data = 32'hBB; i_wr_be = 4'hF;
        i_rd_req_valid = 1'b1; i_rd_addr = 10'd7; i_rd_ready = 1'b1;
        tick();
        i_wr_valid = 1'b0; i_rd_req_valid = 1'b0;
`ifdef BRAM_RV_WRITE_FIRST_EN
        check("collide", o_rd_data, 32'hBB);
`else
        check("collide", o_rd_data, 32'hAA);
`endif
        tick();
        rd_check(10'd7, 32'hBB, "after_collide");

        // Reset with two responses buffered
        i_rd_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            i_rd_req_valid = 1'b1; i_rd_addr = a4[i];
            tick();
        end
        i_rd_req_valid = 1'b0;
        check("full_valid", 32'(o_rd_valid), 32'd1);
        i_rst = 1'b0;
        #1;
        check("midrst_valid", 32'(o_rd_valid), 32'd0);
        check("midrst_data", o_rd_data, 32'd0);
        tick();
        i_rst = 1'b1;
        tick();
        check("post_rst_empty", 32'(o_rd_valid), 32'd0);
        rd_check(10'd5, 32'h1122FF44, "retain5");
        rd_check(10'd21, 32'hAA, "retain21");

        // Randomized traffic: first seed every address the traffic can touch
        for (int i = 0; i < 16; i++) wr(AW'(i), $urandom, 4'hF);
        for (int i = 1008; i < 1024; i++) wr(AW'(i), $urandom, 4'hF);
        for (int c = 0; c < 3000; c++) begin
            i_wr_valid     = ($urandom_range(0, 1) == 1);
            i_wr_addr      = pick_addr();
            i_wr_data      = $urandom;
            i_wr_be        = 4'($urandom_range(0, 15));
            i_rd_req_valid = ($urandom_range(0, 3) != 0);
            i_rd_addr      = ($urandom_range(0, 3) == 0) ? i_wr_addr : pick_addr();
            i_rd_ready     = (c % 200 < 100) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 3) == 0);
            if (c == 1500) i_rst = 1'b0;
            if (c == 1503) i_rst = 1'b1;
            tick();
        end
        i_wr_valid = 1'b0; i_rd_req_valid = 1'b0; i_rd_ready = 1'b1;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
